// File: rtl/spi_tpm_reg_bridge_if.sv
// ---------------------------------------------------------------------------
// spi_tpm_reg_bridge_if
// Byte handshake with spi_periph plus the single-byte TPM register bus.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

interface spi_tpm_reg_bridge_if;
  logic [7:0]  spi_data_i;
  logic [15:0] spi_addr_i;
  logic        spi_data_wr_i;
  logic        spi_wr_done_o;
  logic        spi_data_req_i;
  logic [7:0]  spi_data_o;
  logic        spi_data_rd_o;
  logic [15:0] reg_addr_o;
  logic [7:0]  reg_wdata_o;
  logic        reg_we_o;
  logic        reg_re_o;
  logic [7:0]  reg_rdata_i;
  logic        reg_ack_i;
  logic        timeout_o;

  // The bridge itself
  modport slave (
    input  spi_data_i, spi_addr_i, spi_data_wr_i, spi_data_req_i,
           reg_rdata_i, reg_ack_i,
    output spi_wr_done_o, spi_data_o, spi_data_rd_o,
           reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, timeout_o
  );

  // The surrounding environment (spi_periph side plus register file)
  modport master (
    output spi_data_i, spi_addr_i, spi_data_wr_i, spi_data_req_i,
           reg_rdata_i, reg_ack_i,
    input  spi_wr_done_o, spi_data_o, spi_data_rd_o,
           reg_addr_o, reg_wdata_o, reg_we_o, reg_re_o, timeout_o
  );
endinterface

`default_nettype wire

// File: rtl/spi_tpm_reg_bridge.sv
// ---------------------------------------------------------------------------
// spi_tpm_reg_bridge
// Turns spi_periph byte strobes into single-byte TPM register accesses.
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module spi_tpm_reg_bridge #(
  parameter int NUM_LOCALITIES = 5,
  parameter int TIMEOUT        = 255
) (
  input  logic                   clk_i,
  input  logic                   rst_n_i,
  spi_tpm_reg_bridge_if.slave    bus
);

  localparam logic [4:0]  LOC_LIMIT   = 5'(NUM_LOCALITIES);
  localparam logic [15:0] TIMER_LIMIT = 16'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE    = 3'd0,
    WR_BUS  = 3'd1,
    WR_HOLD = 3'd2,
    RD_BUS  = 3'd3,
    RD_HOLD = 3'd4
  } state_t;

  state_t      state;
  logic [2:0]  wr_sync;
  logic [2:0]  req_sync;
  logic        wr_rise;
  logic        req_rise;
  logic        addr_valid;
  logic        rd_pending;
  logic [15:0] timer;

  logic        wr_done;
  logic [7:0]  data_out;
  logic        data_rd;
  logic [15:0] reg_addr;
  logic [7:0]  reg_wdata;
  logic        reg_we;
  logic        reg_re;
  logic        timeout_pulse;

  // Bits [1:0] form the synchronizer, bit [2] is the edge-history flop
  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      wr_sync  <= 3'b000;
      req_sync <= 3'b000;
    end else begin
      wr_sync  <= {wr_sync[1:0], bus.spi_data_wr_i};
      req_sync <= {req_sync[1:0], bus.spi_data_req_i};
    end
  end

  assign wr_rise    = wr_sync[1] & ~wr_sync[2];
  assign req_rise   = req_sync[1] & ~req_sync[2];
  assign addr_valid = ({1'b0, bus.spi_addr_i[15:12]} < LOC_LIMIT);

  always_ff @(posedge clk_i or negedge rst_n_i) begin
    if (!rst_n_i) begin
      state         <= IDLE;
      rd_pending    <= 1'b0;
      timer         <= 16'd0;
      wr_done       <= 1'b0;
      data_out      <= 8'h00;
      data_rd       <= 1'b0;
      reg_addr      <= 16'h0000;
      reg_wdata     <= 8'h00;
      reg_we        <= 1'b0;
      reg_re        <= 1'b0;
      timeout_pulse <= 1'b0;
    end else begin
      timeout_pulse <= 1'b0;
      // A read strobe arriving while a write is in flight waits its turn
      if (req_rise && (state == WR_BUS || state == WR_HOLD)) begin
        rd_pending <= 1'b1;
      end
      case (state)
        IDLE: begin
          if (wr_rise) begin
            rd_pending <= rd_pending | req_rise;
            if (addr_valid) begin
              reg_addr  <= bus.spi_addr_i;
              reg_wdata <= bus.spi_data_i;
              reg_we    <= 1'b1;
              timer     <= 16'd0;
              state     <= WR_BUS;
            end else begin
              wr_done <= 1'b1;
              state   <= WR_HOLD;
            end
          end else if (req_rise || rd_pending) begin
            rd_pending <= 1'b0;
            if (addr_valid) begin
              reg_addr <= bus.spi_addr_i;
              reg_re   <= 1'b1;
              timer    <= 16'd0;
              state    <= RD_BUS;
            end else begin
              data_out <= 8'hFF;
              data_rd  <= 1'b1;
              state    <= RD_HOLD;
            end
          end
        end
        WR_BUS: begin
          if (bus.reg_ack_i) begin
            reg_we  <= 1'b0;
            wr_done <= 1'b1;
            state   <= WR_HOLD;
          end else if (timer == TIMER_LIMIT) begin
            reg_we        <= 1'b0;
            wr_done       <= 1'b1;
            timeout_pulse <= 1'b1;
            state         <= WR_HOLD;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        WR_HOLD: begin
          if (!wr_sync[1]) begin
            wr_done <= 1'b0;
            state   <= IDLE;
          end
        end
        RD_BUS: begin
          if (bus.reg_ack_i) begin
            data_out <= bus.reg_rdata_i;
            reg_re   <= 1'b0;
            data_rd  <= 1'b1;
            state    <= RD_HOLD;
          end else if (timer == TIMER_LIMIT) begin
            data_out      <= 8'hFF;
            reg_re        <= 1'b0;
            data_rd       <= 1'b1;
            timeout_pulse <= 1'b1;
            state         <= RD_HOLD;
          end else begin
            timer <= timer + 16'd1;
          end
        end
        RD_HOLD: begin
          // Level check so a strobe that dropped during a long access is not missed
          if (!req_sync[1]) begin
            data_rd <= 1'b0;
            state   <= IDLE;
          end
        end
        default: begin
          state <= IDLE;
        end
      endcase
    end
  end

  assign bus.spi_wr_done_o = wr_done;
  assign bus.spi_data_o    = data_out;
  assign bus.spi_data_rd_o = data_rd;
  assign bus.reg_addr_o    = reg_addr;
  assign bus.reg_wdata_o   = reg_wdata;
  assign bus.reg_we_o      = reg_we;
  assign bus.reg_re_o      = reg_re;
  assign bus.timeout_o     = timeout_pulse;

endmodule

`default_nettype wire

// File: tb/tb_spi_tpm_reg_bridge.sv
// ---------------------------------------------------------------------------
// tb_spi_tpm_reg_bridge
// Directed scoreboard bench for spi_tpm_reg_bridge (NUM_LOCALITIES=5, TIMEOUT=20).
// Revision: 1.0
// ---------------------------------------------------------------------------
`default_nettype none

module tb_spi_tpm_reg_bridge;

  typedef struct packed {
    logic        we;
    logic [15:0] addr;
    logic [7:0]  wdata;
  } bus_t;

  logic clk;
  logic rst_n;
  spi_tpm_reg_bridge_if sif();

  spi_tpm_reg_bridge #(.NUM_LOCALITIES(5), .TIMEOUT(20)) dut (
    .clk_i   (clk),
    .rst_n_i (rst_n),
    .bus     (sif)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  bus_t       exp_bus[$];
  logic [7:0] exp_rd[$];
  int         total = 0;
  int         bad = 0;
  logic       both_seen = 1'b0;

  always @(negedge clk) if (sif.reg_we_o && sif.reg_re_o) both_seen = 1'b1;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic wait_start(output int n);
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (!(sif.reg_we_o || sif.reg_re_o || sif.spi_wr_done_o || sif.spi_data_rd_o) && n < 40);
  endtask

  task automatic check_bus_start();
    bus_t e;
    chk("bus_expected", 32'(exp_bus.size() != 0), 1);
    if (exp_bus.size() != 0) begin
      e = exp_bus.pop_front();
      chk("bus_we", sif.reg_we_o, e.we);
      chk("bus_re", sif.reg_re_o, !e.we);
      chk("bus_addr", sif.reg_addr_o, e.addr);
      if (e.we) chk("bus_wdata", sif.reg_wdata_o, e.wdata);
    end
  endtask

  task automatic check_rd();
    chk("rd_expected", 32'(exp_rd.size() != 0), 1);
    if (exp_rd.size() != 0) chk("rd_data", sif.spi_data_o, exp_rd.pop_front());
  endtask

  // Holds the request, acks on its ack_at-th cycle (0 = never), counts cycles high
  task automatic serve(input int ack_at, input logic [7:0] rdata, output int high, output logic to);
    logic [15:0] a0;
    logic [7:0]  w0;
    logic        chg;
    a0 = sif.reg_addr_o;
    w0 = sif.reg_wdata_o;
    chg = 1'b0;
    high = 1;
    while (high < 200) begin
      if (ack_at != 0 && high == ack_at) begin
        sif.reg_ack_i   = 1'b1;
        sif.reg_rdata_i = rdata;
      end
      @(negedge clk);
      sif.reg_ack_i = 1'b0;
      if (!(sif.reg_we_o || sif.reg_re_o)) break;
      if (sif.reg_addr_o !== a0 || sif.reg_wdata_o !== w0) chg = 1'b1;
      high++;
    end
    to = sif.timeout_o;
    chk("bus_stable", chg, 0);
  endtask

  task automatic end_wr();
    int n;
    sif.spi_data_wr_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sif.spi_wr_done_o && n < 40);
    chk("wr_done_release", n, 3);
  endtask

  task automatic end_rd();
    int n;
    sif.spi_data_req_i = 1'b0;
    n = 0;
    do begin
      @(negedge clk);
      n++;
    end while (sif.spi_data_rd_o && n < 40);
    chk("rd_release", n, 3);
  endtask

  task automatic do_write(input logic [15:0] a, input logic [7:0] d, input bit valid,
                          input int ack_at, input int exp_high, input bit exp_to);
    int   n;
    int   high;
    logic to;
    sif.spi_addr_i    = a;
    sif.spi_data_i    = d;
    sif.spi_data_wr_i = 1'b1;
    if (valid) exp_bus.push_back('{we: 1'b1, addr: a, wdata: d});
    wait_start(n);
    chk("wr_latency", n, 3);
    if (valid) begin
      check_bus_start();
      serve(ack_at, 8'h00, high, to);
      chk("wr_req_cycles", high, exp_high);
      chk("wr_timeout", to, exp_to);
    end else begin
      chk("wr_no_bus", {sif.reg_we_o, sif.reg_re_o}, 0);
    end
    chk("wr_done", sif.spi_wr_done_o, 1);
    end_wr();
  endtask

  task automatic do_read(input logic [15:0] a, input bit valid, input int ack_at,
                         input logic [7:0] rdata, input int exp_high, input bit exp_to,
                         input logic [7:0] exp_data);
    int   n;
    int   high;
    logic to;
    sif.spi_addr_i     = a;
    sif.spi_data_req_i = 1'b1;
    exp_rd.push_back(exp_data);
    if (valid) exp_bus.push_back('{we: 1'b0, addr: a, wdata: 8'h00});
    wait_start(n);
    chk("rd_latency", n, 3);
    if (valid) begin
      check_bus_start();
      serve(ack_at, rdata, high, to);
      chk("rd_req_cycles", high, exp_high);
      chk("rd_timeout", to, exp_to);
    end else begin
      chk("rd_no_bus", {sif.reg_we_o, sif.reg_re_o}, 0);
    end
    chk("rd_strobe", sif.spi_data_rd_o, 1);
    check_rd();
    end_rd();
  endtask

  initial begin
    int          n;
    int          high;
    logic        to;
    logic [31:0] word;
    logic [7:0]  bytes_in [4];

    rst_n              = 1'b0;
    sif.spi_data_i     = 8'h00;
    sif.spi_addr_i     = 16'h0000;
    sif.spi_data_wr_i  = 1'b0;
    sif.spi_data_req_i = 1'b0;
    sif.reg_rdata_i    = 8'h00;
    sif.reg_ack_i      = 1'b0;
    repeat (3) @(negedge clk);
    chk("rst_outputs", {sif.spi_wr_done_o, sif.spi_data_rd_o, sif.reg_we_o, sif.reg_re_o, sif.timeout_o}, 0);
    chk("rst_data", sif.spi_data_o, 8'h00);
    chk("rst_addr", sif.reg_addr_o, 16'h0000);
    rst_n = 1'b1;
    repeat (2) @(negedge clk);

    // Zero-wait write
    do_write(16'h0018, 8'h3C, 1'b1, 1, 1, 1'b0);

    // Read with a 10-cycle ack delay, then four back-to-back reads
    do_read(16'h0F00, 1'b1, 10, 8'hA5, 10, 1'b0, 8'hA5);
    bytes_in[0] = 8'hB0;
    bytes_in[1] = 8'hE8;
    bytes_in[2] = 8'h12;
    bytes_in[3] = 8'h07;
    word = 32'h0;
    for (int i = 0; i < 4; i++) begin
      do_read(16'h0024 + 16'(i), 1'b1, 2, bytes_in[i], 2, 1'b0, bytes_in[i]);
      word[8*i +: 8] = sif.spi_data_o;
    end
    chk("rd_word", word, 32'h0712E8B0);

    // Locality filter
    do_write(16'h5000, 8'h77, 1'b0, 0, 0, 1'b0);
    do_read(16'hF00F, 1'b0, 0, 8'h00, 0, 1'b0, 8'hFF);
    do_read(16'h4001, 1'b1, 1, 8'h6D, 1, 1'b0, 8'h6D);

    // Timeouts
    do_read(16'h0010, 1'b1, 0, 8'h00, 21, 1'b1, 8'hFF);
    do_write(16'h0011, 8'h55, 1'b1, 0, 21, 1'b1);
    do_write(16'h0012, 8'h66, 1'b1, 20, 20, 1'b0);
    do_read(16'h0013, 1'b1, 21, 8'h3E, 21, 1'b0, 8'h3E);

    // Simultaneous write and read strobes: write first, then the read
    sif.spi_addr_i     = 16'h0100;
    sif.spi_data_i     = 8'h9C;
    sif.spi_data_wr_i  = 1'b1;
    sif.spi_data_req_i = 1'b1;
    exp_bus.push_back('{we: 1'b1, addr: 16'h0100, wdata: 8'h9C});
    exp_bus.push_back('{we: 1'b0, addr: 16'h0100, wdata: 8'h00});
    exp_rd.push_back(8'h5A);
    wait_start(n);
    chk("sim_wr_latency", n, 3);
    check_bus_start();
    serve(1, 8'h00, high, to);
    chk("sim_wr_done", sif.spi_wr_done_o, 1);
    chk("sim_no_rd_yet", sif.spi_data_rd_o, 0);
    end_wr();
    wait_start(n);
    chk("sim_rd_follow", n, 1);
    check_bus_start();
    serve(3, 8'h5A, high, to);
    chk("sim_rd_cycles", high, 3);
    chk("sim_rd_strobe", sif.spi_data_rd_o, 1);
    check_rd();
    end_rd();

    // Stray ack while idle must be ignored
    sif.reg_ack_i   = 1'b1;
    sif.reg_rdata_i = 8'h99;
    @(negedge clk);
    sif.reg_ack_i = 1'b0;
    repeat (2) @(negedge clk);
    chk("idle_ack_quiet", {sif.spi_wr_done_o, sif.spi_data_rd_o, sif.reg_we_o, sif.reg_re_o, sif.timeout_o}, 0);
    chk("idle_ack_data", sif.spi_data_o, 8'h5A);

    // Reset during RD_BUS, then the still-high strobe is re-issued
    sif.spi_addr_i     = 16'h1234;
    sif.spi_data_req_i = 1'b1;
    exp_bus.push_back('{we: 1'b0, addr: 16'h1234, wdata: 8'h00});
    wait_start(n);
    check_bus_start();
    repeat (2) @(negedge clk);
    rst_n = 1'b0;
    #1;
    chk("rst_mid_outputs", {sif.reg_re_o, sif.spi_data_rd_o, sif.timeout_o}, 0);
    chk("rst_mid_data", sif.spi_data_o, 8'h00);
    repeat (2) @(negedge clk);
    rst_n = 1'b1;
    exp_bus.push_back('{we: 1'b0, addr: 16'h1234, wdata: 8'h00});
    exp_rd.push_back(8'hC3);
    wait_start(n);
    chk("rst_reissue_latency", n, 3);
    check_bus_start();
    serve(2, 8'hC3, high, to);
    chk("rst_reissue_strobe", sif.spi_data_rd_o, 1);
    check_rd();
    end_rd();

    chk("we_re_exclusive", both_seen, 0);
    chk("bus_queue_drained", exp_bus.size(), 0);
    chk("rd_queue_drained", exp_rd.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule

`default_nettype wire

// File: doc/spi_tpm_reg_bridge.md
Name: spi_tpm_reg_bridge

Overview:
- Data provider sitting directly downstream of spi_periph.
- Services its per-byte write (data_wr/wr_done) and read (data_req/data_rd) handshakes on the system clock.
- Turns each byte into a single-byte access on a simple TPM register bus with ack and timeout.
- Filters TPM localities and returns 0xFF on unserviced reads.

Parameters:
- NUM_LOCALITIES, 5, localities 0..NUM_LOCALITIES-1 forwarded to the register bus (range 1..16).
- TIMEOUT, 255, clk_i cycles to wait for reg_ack_i before aborting (range 1..65535).

Ports:
- clk_i  input  1  system clock
- rst_n_i  input  1  asynchronous active-low reset
- spi_data_i  input  8  write byte from spi_periph data_o; stable while spi_data_wr_i high
- spi_addr_i  input  16  byte address from spi_periph addr_o; stable while either strobe high
- spi_data_wr_i  input  1  spi_periph data_wr; asynchronous to clk_i
- spi_wr_done_o  output  1  to spi_periph wr_done
- spi_data_req_i  input  1  spi_periph data_req; asynchronous to clk_i
- spi_data_o  output  8  read byte to spi_periph data_i
- spi_data_rd_o  output  1  to spi_periph data_rd
- reg_addr_o  output  16  register bus byte address
- reg_wdata_o  output  8  register bus write data
- reg_we_o  output  1  write request, held until ack/timeout
- reg_re_o  output  1  read request, held until ack/timeout
- reg_rdata_i  input  8  read data, valid with reg_ack_i
- reg_ack_i  input  1  single-cycle completion pulse
- timeout_o  output  1  one-cycle pulse on aborted access

Behaviour:
- Clock and reset: single clock clk_i; rst_n_i is asynchronous, active-low.
- Reset values: all outputs 0, spi_data_o = 8'h00, FSM in IDLE, synchronizers 0.
- Synchronization: spi_data_wr_i and spi_data_req_i each pass through a 2-flop synchronizer plus one history flop.
  - rise = s2 & ~s3; fall = ~s2 & s3.
  - Detection occurs on the 3rd clk_i edge after the input changes.
- Locality: locality = spi_addr_i[15:12].
  - Access is valid when locality < NUM_LOCALITIES.
  - Invalid write: no bus access; the byte is dropped.
  - Invalid read: no bus access; returns 8'hFF.
- FSM states: IDLE, WR_BUS, WR_HOLD, RD_BUS, RD_HOLD.
  - IDLE, wr rise, valid: latch addr/data into reg_addr_o/reg_wdata_o, reg_we_o=1, go to WR_BUS.
  - IDLE, wr rise, invalid: spi_wr_done_o=1, go to WR_HOLD.
  - IDLE, req rise, valid: latch addr, reg_re_o=1, go to RD_BUS.
  - IDLE, req rise, invalid: spi_data_o=FF, spi_data_rd_o=1, go to RD_HOLD.
  - IDLE, both rises in the same cycle: write is serviced first; the read rise is remembered as pending and serviced on return to IDLE.
  - WR_BUS: on reg_ack_i, reg_we_o=0, spi_wr_done_o=1, go to WR_HOLD. On timer == TIMEOUT, same transition plus timeout_o pulse.
  - RD_BUS: on reg_ack_i, capture reg_rdata_i into spi_data_o, reg_re_o=0, spi_data_rd_o=1, go to RD_HOLD. On timeout, spi_data_o=FF, timeout_o pulse, same transition.
  - WR_HOLD: on wr fall (or s2 already 0), spi_wr_done_o=0, go to IDLE.
  - RD_HOLD: on req fall, spi_data_rd_o=0, go to IDLE.
- Timeout counter: 16 bits, cleared on entry to *_BUS, increments each cycle in *_BUS.
- Ack in the same cycle as timer == TIMEOUT: ack wins, no timeout_o pulse.
- Bus rules:
  - At most one outstanding access.
  - reg_we_o and reg_re_o are never both high.
  - reg_addr_o and reg_wdata_o are stable while the request is high.
  - reg_ack_i outside *_BUS is ignored.
- spi_data_o holds its last value until the next read completes.
- Latency: wr rise to reg_we_o = 3 clk_i edges; ack to spi_wr_done_o = 1 edge; same for reads.
- Reset mid-operation: all outputs return to reset values immediately.
  - A strobe still high after reset release is seen as a rise and serviced again.
  - This is acceptable, since spi_periph re-requests after its own reset.
- Address arithmetic: none; spi_addr_i is forwarded unchanged (16 bits, no wrap).

Test Plan:
- Write, zero-wait bus: spi_addr=0x0018, data=0x3C, ack 1 cycle after reg_we_o -> reg_we_o with addr 0x0018/wdata 0x3C for exactly 1 cycle; spi_wr_done_o high until data_wr falls, low 3 edges later.
- Read with 10-cycle ack delay: addr 0x0F00, reg_rdata=0xA5 -> spi_data_o=0xA5 with spi_data_rd_o; then 4 back-to-back reads of 0xB0,0xE8,0x12,0x07 -> assembled 32'h0712E8B0.
- Locality filter (NUM_LOCALITIES=5): write to 0x5000 and read from 0xF00F -> no reg_we_o/reg_re_o; wr_done asserted; read returns 0xFF.
- Timeout (TIMEOUT=20), no ack: read -> reg_re_o high 21 cycles, timeout_o pulse, spi_data_o=0xFF, spi_data_rd_o asserted; write likewise completes wr_done.
- Simultaneous data_wr/data_req rise -> write bus cycle, then read bus cycle; both handshakes complete in order.
- rst_n_i low during RD_BUS -> reg_re_o, spi_data_rd_o and timeout_o immediately 0; after release with data_req still high the read is re-issued.
